// File: rtl/pcie_dma_responder.sv
// DMA completion engine: validates one descriptor, then copies it beat-by-beat
// over the local memory port. Optional watchdog enabled by PCIE_DMA_TIMEOUT_EN.
module pcie_dma_responder #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] LOCAL_BASE = 64'h8000_0000,
  parameter logic [ADDR_WIDTH-1:0] LOCAL_SIZE = 64'h1000_0000,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dma_req_valid,
  output logic                  dma_req_ready,
  input  logic [ADDR_WIDTH-1:0] dma_src_addr,
  input  logic [ADDR_WIDTH-1:0] dma_dst_addr,
  input  logic [31:0]           dma_length,
  input  logic                  dma_write,
  output logic                  dma_done,
  output logic                  dma_error,
  output logic [1:0]            dma_err_code,
  output logic                  mem_rd_req,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic                  mem_rd_gnt,
  input  logic                  mem_rd_valid,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  mem_wr_req,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic                  mem_wr_gnt
);

  localparam int BEAT_BYTES = DATA_WIDTH / 8;
  localparam int BEAT_LSB   = $clog2(BEAT_BYTES);
  localparam logic [31:0] BEAT_LEN = 32'(BEAT_BYTES);
  localparam logic [ADDR_WIDTH:0] WIN_LO = {1'b0, LOCAL_BASE};
  localparam logic [ADDR_WIDTH:0] WIN_HI = {1'b0, LOCAL_BASE} + {1'b0, LOCAL_SIZE};

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CHECK   = 3'd1;
  localparam logic [2:0] RD_REQ  = 3'd2;
  localparam logic [2:0] RD_WAIT = 3'd3;
  localparam logic [2:0] WR_REQ  = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;
  localparam logic [2:0] ERR     = 3'd6;

  if (ADDR_WIDTH < 32) begin : g_bad_addr_width
    $error("ADDR_WIDTH must be at least 32");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  logic [2:0]            state;
  logic [2:0]            state_nxt;
  logic                  alive;
  logic [ADDR_WIDTH-1:0] src_cur;
  logic [ADDR_WIDTH-1:0] dst_cur;
  logic [31:0]           rem;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] rd_buf;
  logic [1:0]            err_code;

  logic                  accept;
  logic                  waiting;
  logic                  tmo;
  logic                  bad_len;
  logic                  bad_win;
  logic [ADDR_WIDTH:0]   len_ext;
  logic [ADDR_WIDTH:0]   src_end;
  logic [ADDR_WIDTH:0]   dst_end;
  logic [ADDR_WIDTH:0]   loc_lo;
  logic [ADDR_WIDTH:0]   loc_hi;

  // alive holds ready low for the first cycle after reset release
  assign dma_req_ready = alive && (state == IDLE);
  assign accept        = dma_req_valid && dma_req_ready;
  assign waiting       = (state == RD_REQ) || (state == RD_WAIT) || (state == WR_REQ);

  // Descriptor checks; only meaningful while in CHECK, before rem starts counting down
  assign len_ext = (ADDR_WIDTH+1)'(rem);
  assign src_end = {1'b0, src_cur} + len_ext;
  assign dst_end = {1'b0, dst_cur} + len_ext;
  assign loc_lo  = write_q ? {1'b0, dst_cur} : {1'b0, src_cur};
  assign loc_hi  = write_q ? dst_end : src_end;

  assign bad_len = (rem == 32'd0)
                || (rem[BEAT_LSB-1:0] != '0)
                || (src_cur[BEAT_LSB-1:0] != '0)
                || (dst_cur[BEAT_LSB-1:0] != '0);
  assign bad_win = src_end[ADDR_WIDTH] || dst_end[ADDR_WIDTH]
                || (loc_lo < WIN_LO) || (loc_hi > WIN_HI);

`ifdef PCIE_DMA_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wd_cnt;

  // Restarts on every state change, so each wait state gets a full budget
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (state_nxt != state) begin
      wd_cnt <= '0;
    end else if (waiting) begin
      wd_cnt <= wd_cnt + CNT_W'(1);
    end
  end

  assign tmo = waiting && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CHECK;
      CHECK:   state_nxt = (bad_len || bad_win) ? ERR : RD_REQ;
      RD_REQ: begin
        if (mem_rd_gnt)  state_nxt = RD_WAIT;
        else if (tmo)    state_nxt = ERR;
      end
      RD_WAIT: begin
        if (mem_rd_valid) state_nxt = WR_REQ;
        else if (tmo)     state_nxt = ERR;
      end
      WR_REQ: begin
        if (mem_wr_gnt)  state_nxt = (rem == BEAT_LEN) ? DONE : RD_REQ;
        else if (tmo)    state_nxt = ERR;
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      alive    <= 1'b0;
      err_code <= 2'd0;
    end else begin
      state <= state_nxt;
      alive <= 1'b1;
      if (accept) begin
        err_code <= 2'd0;
      end else if (state == CHECK) begin
        if (bad_len)      err_code <= 2'd1;
        else if (bad_win) err_code <= 2'd2;
      end else if (waiting && state_nxt == ERR) begin
        err_code <= 2'd3;
      end
    end
  end

  // Beat addresses and remaining length advance only once the write lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_cur <= '0;
      dst_cur <= '0;
      rem     <= '0;
      write_q <= 1'b0;
      rd_buf  <= '0;
    end else begin
      if (accept) begin
        src_cur <= dma_src_addr;
        dst_cur <= dma_dst_addr;
        rem     <= dma_length;
        write_q <= dma_write;
      end else if (state == WR_REQ && mem_wr_gnt) begin
        src_cur <= src_cur + ADDR_WIDTH'(BEAT_BYTES);
        dst_cur <= dst_cur + ADDR_WIDTH'(BEAT_BYTES);
        rem     <= rem - BEAT_LEN;
      end
      if (state == RD_WAIT && mem_rd_valid) begin
        rd_buf <= mem_rd_data;
      end
    end
  end

  assign dma_done     = (state == DONE);
  assign dma_error    = (state == ERR);
  assign dma_err_code = err_code;
  assign mem_rd_req   = (state == RD_REQ);
  assign mem_rd_addr  = src_cur;
  assign mem_wr_req   = (state == WR_REQ);
  assign mem_wr_addr  = dst_cur;
  assign mem_wr_data  = rd_buf;

endmodule

// File: tb/tb_pcie_dma_responder.sv
// Directed bench for pcie_dma_responder with a small handshaking memory model.
module tb_pcie_dma_responder;
  localparam int DW  = 512;
  localparam int AW  = 64;
  localparam int TMO = 1024;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          dma_req_valid;
  logic          dma_req_ready;
  logic [AW-1:0] dma_src_addr;
  logic [AW-1:0] dma_dst_addr;
  logic [31:0]   dma_length;
  logic          dma_write;
  logic          dma_done;
  logic          dma_error;
  logic [1:0]    dma_err_code;
  logic          mem_rd_req;
  logic [AW-1:0] mem_rd_addr;
  logic          mem_rd_gnt;
  logic          mem_rd_valid;
  logic [DW-1:0] mem_rd_data;
  logic          mem_wr_req;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic          mem_wr_gnt;

  pcie_dma_responder #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready),
    .dma_src_addr(dma_src_addr), .dma_dst_addr(dma_dst_addr),
    .dma_length(dma_length), .dma_write(dma_write),
    .dma_done(dma_done), .dma_error(dma_error), .dma_err_code(dma_err_code),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_gnt(mem_rd_gnt),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .mem_wr_gnt(mem_wr_gnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {16{a[31:0] ^ 32'hA5C3_0000}};
  endfunction

  // Memory model state and monitors
  int            gnt_delay   = 0;
  bit            rd_valid_en = 1'b1;
  int            rd_cnt = 0;
  int            wr_cnt = 0;
  bit            vld_pend = 1'b0;
  logic [AW-1:0] vld_addr;
  logic [AW-1:0] rd_log[$];
  logic [AW-1:0] wr_alog[$];
  logic [DW-1:0] wr_dlog[$];
  int            n_done = 0;
  int            n_err  = 0;
  bit            rd_seen  = 1'b0;
  bit            unstable = 1'b0;
  logic [AW-1:0] held_ra;
  logic [AW-1:0] held_wa;
  logic [DW-1:0] held_wd;

  initial begin : mem_model
    mem_rd_gnt = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0; mem_wr_gnt = 1'b0;
    forever begin
      @(negedge clk);
      mem_rd_gnt = 1'b0; mem_rd_valid = 1'b0; mem_wr_gnt = 1'b0;
      if (dma_done)  n_done++;
      if (dma_error) n_err++;
      if (!rst_n) begin
        vld_pend = 1'b0; rd_cnt = 0; wr_cnt = 0;
      end else begin
        if (vld_pend && rd_valid_en) begin
          mem_rd_valid = 1'b1; mem_rd_data = pat(vld_addr); vld_pend = 1'b0;
        end
        if (mem_rd_req) begin
          rd_seen = 1'b1;
          if (rd_cnt == 0) held_ra = mem_rd_addr;
          else if (mem_rd_addr !== held_ra) unstable = 1'b1;
          if (rd_cnt >= gnt_delay) begin
            mem_rd_gnt = 1'b1; rd_log.push_back(mem_rd_addr);
            vld_addr = mem_rd_addr; vld_pend = 1'b1; rd_cnt = 0;
          end else rd_cnt++;
        end
        if (mem_wr_req) begin
          if (wr_cnt == 0) begin
            held_wa = mem_wr_addr; held_wd = mem_wr_data;
          end else if (mem_wr_addr !== held_wa || mem_wr_data !== held_wd) unstable = 1'b1;
          if (wr_cnt >= gnt_delay) begin
            mem_wr_gnt = 1'b1; wr_alog.push_back(mem_wr_addr);
            wr_dlog.push_back(mem_wr_data); wr_cnt = 0;
          end else wr_cnt++;
        end
      end
    end
  end

  task automatic clear_mon();
    n_done = 0; n_err = 0; rd_seen = 1'b0; unstable = 1'b0;
    rd_log.delete(); wr_alog.delete(); wr_dlog.delete();
  endtask

  task automatic issue(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                       input logic [31:0] len, input logic wr);
    int n = 0;
    @(negedge clk);
    while (!dma_req_ready && n < 50) begin
      @(negedge clk); n++;
    end
    if (!dma_req_ready) chk("ready_wait", 0, 1);
    dma_src_addr = src; dma_dst_addr = dst; dma_length = len; dma_write = wr;
    dma_req_valid = 1'b1;
    @(posedge clk);
    #1 dma_req_valid = 1'b0;
  endtask

  // n counts falling edges after the accepting edge: 1 = CHECK, 2 = first possible pulse
  task automatic wait_end(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!(dma_done || dma_error) && n < max);
    #1;
  endtask

  task automatic release_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk({tag, "_ready_lo"}, dma_req_ready, 0);
    @(posedge clk);
    #1 chk({tag, "_ready_hi"}, dma_req_ready, 1);
  endtask

  function automatic logic any_out();
    return |{dma_req_ready, dma_done, dma_error, dma_err_code, mem_rd_req, mem_rd_addr,
             mem_wr_req, mem_wr_addr, mem_wr_data};
  endfunction

  initial begin : main
    int n;
    rst_n = 1'b0; dma_req_valid = 1'b0; dma_src_addr = '0; dma_dst_addr = '0;
    dma_length = '0; dma_write = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk("rst_outs", any_out(), 0);
    release_reset("rst");

    // Basic 4-beat host->device copy
    clear_mon();
    issue(64'h1000, 64'h8000_0000, 32'd256, 1'b1);
    wait_end(200, n);
    chk("t1_done", n_done, 1);
    chk("t1_err", n_err, 0);
    chk("t1_code", dma_err_code, 0);
    chk("t1_nrd", rd_log.size(), 4);
    chk("t1_nwr", wr_alog.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < rd_log.size()) chk($sformatf("t1_rd%0d", i), rd_log[i], 64'h1000 + 64*i);
      if (i < wr_alog.size()) begin
        chk($sformatf("t1_wa%0d", i), wr_alog[i], 64'h8000_0000 + 64*i);
        chk($sformatf("t1_wd%0d", i), wr_dlog[i], pat(64'h1000 + 64*i));
      end
    end

    // Zero length: error exactly two cycles after accept, no memory traffic
    clear_mon();
    issue(64'h1000, 64'h8000_0000, 32'd0, 1'b1);
    @(negedge clk);
    #1 chk("t2_err_t1", dma_error, 0);
    @(negedge clk);
    #1 chk("t2_err_t2", dma_error, 1);
    chk("t2_code", dma_err_code, 1);
    repeat (3) @(negedge clk);
    #1 chk("t2_no_rd", rd_seen, 0);
    chk("t2_npulse", n_err, 1);

    clear_mon();
    issue(64'h1000, 64'h8000_0000, 32'd100, 1'b1);
    wait_end(20, n);
    chk("t2b_code", dma_err_code, 1);
    chk("t2b_lat", n, 2);

    // Window checks on the local side
    clear_mon();
    issue(64'h1000, 64'h8FFF_FFC0, 32'd128, 1'b1);
    wait_end(20, n);
    chk("t3a_err", dma_error, 1);
    chk("t3a_code", dma_err_code, 2);
    clear_mon();
    issue(64'h7FFF_FFC0, 64'h4000, 32'd128, 1'b0);
    wait_end(20, n);
    chk("t3b_err", dma_error, 1);
    chk("t3b_code", dma_err_code, 2);
    clear_mon();
    issue(64'h8FFF_FFC0, 64'h4000, 32'd64, 1'b0);
    wait_end(50, n);
    chk("t3c_done", dma_done, 1);
    chk("t3c_code", dma_err_code, 0);
    chk("t3c_wa", (wr_alog.size() > 0) ? wr_alog[0] : 64'h0, 64'h4000);

    // Slow grants: request lines must hold steady
    clear_mon();
    gnt_delay = 5;
    issue(64'h2000, 64'h8000_1000, 32'd128, 1'b1);
    wait_end(200, n);
    chk("t4_done", n_done, 1);
    chk("t4_nwr", wr_alog.size(), 2);
    chk("t4_stable", unstable, 0);
    chk("t4_wa1", (wr_alog.size() > 1) ? wr_alog[1] : 64'h0, 64'h8000_1040);
    chk("t4_wd1", (wr_dlog.size() > 1) ? wr_dlog[1] : '0, pat(64'h2040));
    gnt_delay = 0;

    // Read data never returns
    clear_mon();
    rd_valid_en = 1'b0;
    issue(64'h3000, 64'h8000_2000, 32'd64, 1'b1);
`ifdef PCIE_DMA_TIMEOUT_EN
    wait_end(3 * TMO, n);
    chk("t5_err", dma_error, 1);
    chk("t5_code", dma_err_code, 3);
    chk("t5_lat", n, TMO + 3);
    chk("t5_rdreq", mem_rd_req, 0);
`else
    repeat (2 * TMO) @(negedge clk);
    #1 chk("t5_pulses", n_done + n_err, 0);
    chk("t5_busy", dma_req_ready, 0);
    chk("t5_nrd", rd_log.size(), 1);
`endif
    rd_valid_en = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    release_reset("t5rst");

    // Reset in the middle of beat 2
    clear_mon();
    issue(64'h1000, 64'h8000_0000, 32'd256, 1'b1);
    n = 0;
    while (rd_log.size() < 2 && n < 100) begin
      @(negedge clk);
      #1 n++;
    end
    chk("t6_reach", rd_log.size(), 2);
    #2 rst_n = 1'b0;
    #1 chk("t6_outs", any_out(), 0);
    repeat (3) @(negedge clk);
    release_reset("t6");
    repeat (5) @(negedge clk);
    #1 chk("t6_pulses", n_done + n_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
